// File: rtl/barrel_shift_cmd_queue.sv
// Command FIFO in front of a combinational 8-bit rotator, with a registered result stage.
// barrel_shifter_8bit is the shifter that the queue drives through its sh_* ports.

module barrel_shifter_8bit (
  input  logic [7:0] in,
  input  logic [2:0] n,
  input  logic       lr,
  output logic [7:0] out
);

  logic [15:0] left_s;
  logic [15:0] right_s;

  // Rotation done as a shift of the doubled operand.
  assign left_s  = {in, in} << n;
  assign right_s = {in, in} >> n;
  assign out     = lr ? left_s[15:8] : right_s[7:0];

endmodule

module barrel_shift_cmd_queue #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [7:0]               in_data,
  input  logic [2:0]               in_n,
  input  logic                     in_lr,
  output logic [7:0]               sh_in,
  output logic [2:0]               sh_n,
  output logic                     sh_lr,
  input  logic [7:0]               sh_out,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [7:0]               out_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
  localparam logic [CW-1:0] ZERO_C = {CW{1'b0}};

  logic [11:0]   mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic [CW-1:0] count_nxt_s;
  logic          out_valid_r;
  logic [7:0]    out_data_r;
  logic [11:0]   head_s;
  logic          push_s;
  logic          pop_s;
  logic          out_free_s;

  assign in_ready   = (count_r != FULL_C) && !rst;
  assign push_s     = in_valid && in_ready;
  assign out_free_s = !out_valid_r || out_ready;
  assign pop_s      = (count_r != ZERO_C) && out_free_s;
  assign head_s     = mem_r[rd_ptr_r];

  assign count     = count_r;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;

  // Head entry to the shifter, forced to zero while the queue is empty.
  always_comb begin
    sh_in = 8'd0;
    sh_n  = 3'd0;
    sh_lr = 1'b0;
    if (count_r != ZERO_C) begin
      sh_in = head_s[7:0];
      sh_n  = head_s[10:8];
      sh_lr = head_s[11];
    end else begin
      sh_in = 8'd0;
      sh_n  = 3'd0;
      sh_lr = 1'b0;
    end
  end

  // Occupancy update; a simultaneous push and pop leaves it unchanged.
  always_comb begin
    count_nxt_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + CW'(1);
      2'b01:   count_nxt_s = count_r - CW'(1);
      default: count_nxt_s = count_r;
    endcase
  end

  // Storage is not reset; stale entries are never visible because count gates the head.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= {in_lr, in_n, in_data};
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= ZERO_C;
    end else begin
      count_r <= count_nxt_s;
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
    end
  end

  // Result register: refill from the shifter on pop, otherwise drop valid once taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      out_data_r  <= 8'd0;
    end else if (pop_s) begin
      out_valid_r <= 1'b1;
      out_data_r  <= sh_out;
    end else if (out_valid_r && out_ready) begin
      out_valid_r <= 1'b0;
    end
  end

endmodule

// File: doc/barrel_shift_cmd_queue.md
# barrel_shift_cmd_queue

Command queue and result register feeding the 8-bit barrel shifter (`barrel_shifter_8bit`).
- Accepts shift commands {data, amount, direction} over a valid/ready handshake and buffers them in a DEPTH-entry FIFO.
- Drives the FIFO head combinationally into the shifter.
- Captures the shifter result into an output register with its own valid/ready handshake.
- Lets a bursty producer and a stalling consumer share one combinational shifter without losing commands.

## Interface
- `DEPTH`, default 4: number of FIFO entries. Must be a power of 2, range 2..16.
- `clk`  input  1: single clock. All state updates on the rising edge.
- `rst`  input  1: reset, asynchronous and active-high.
- `in_valid`  input  1: producer offers a command.
- `in_ready`  output  1: queue can accept. Equals `(count != DEPTH) && !rst`.
- `in_data`  input  8: operand to shift.
- `in_n`  input  3: shift amount, 0..7.
- `in_lr`  input  1: direction. 1 = rotate left, 0 = rotate right.
- `sh_in`  output  8: head operand to the shifter's `in`. 0 when the queue is empty.
- `sh_n`  output  3: head amount to the shifter's `n`. 0 when the queue is empty.
- `sh_lr`  output  1: head direction to the shifter's `lr`. 0 when the queue is empty.
- `sh_out`  input  8: shifter's `out`, combinational function of `sh_*`.
- `out_valid`  output  1: result register holds an unconsumed result.
- `out_ready`  input  1: consumer accepts the result.
- `out_data`  output  8: registered shifter result.
- `count`  output  $clog2(DEPTH)+1: number of FIFO entries held, 0..DEPTH.

## Operation
- Storage: circular buffer of DEPTH entries, each 12 bits {lr, n[2:0], data[7:0]}.
  - Read and write pointers are $clog2(DEPTH) bits wide and wrap modulo DEPTH.
  - `count` is kept as a separate register. It is not derived from the pointers.
- Push:
  - Occurs when `in_valid && in_ready`.
  - Writes the entry at the write pointer, then increments the write pointer.
- Output register free condition: `!out_valid || out_ready`.
- Pop:
  - Occurs when `count != 0` and the output register is free.
  - Loads `out_data <= sh_out`, sets `out_valid <= 1`, and increments the read pointer.
- Consume without refill: when `out_valid && out_ready` and `count == 0`, clear `out_valid <= 0`. `out_data` holds its last value.
- Simultaneous push and pop: `count` is unchanged and both pointers advance.
- Full (`count == DEPTH`):
  - `in_ready = 0`. A push is refused even if a pop occurs in the same cycle; there is no full-bypass.
  - `in_valid` held high while full is not an error. The command is accepted in the first cycle after `count` drops.
- Empty (`count == 0`):
  - `sh_*` drive 0.
  - No pop occurs. There is no input-to-output bypass.
- `in_n`, `in_data` and `in_lr` are ignored when there is no push.
- Commands are processed strictly in FIFO order.
- No command is dropped or duplicated under any `in_valid`/`out_ready` pattern.
- Reset (asynchronous, any cycle):
  - Outputs: `count = 0`, both pointers 0, `out_valid = 0`, `out_data = 0`, `in_ready = 0`.
  - Queued and in-flight commands are discarded.
  - FIFO storage contents need not be cleared.
- First push is possible on the first rising edge after `rst` deasserts.

## Timing
- Command accepted at edge k with queue empty and output register free: `out_valid = 1` and `out_data` valid after edge k+1. Latency is 1 cycle from acceptance.
- Sustained throughput: 1 command per cycle when `in_valid` and `out_ready` are both held high.
- `out_valid`/`out_data` stay stable while `out_valid && !out_ready`.
- `in_ready` is a combinational function of `count` and `rst` only. There is no path from `in_valid` to `in_ready`.
- `sh_in`, `sh_n` and `sh_lr` come from the registered head entry. They change only after a clock edge or on `rst`.
- Combinational path: head registers → shifter → `out_data` D-input, within one cycle.

## Test plan
Bench instantiates `barrel_shifter_8bit` on the `sh_*` ports, with `DEPTH = 4`.
- Reset check: assert `rst` mid-stream with 3 entries queued and `out_valid = 1`. Required immediately: `count = 0`, `out_valid = 0`, `out_data = 0`, `in_ready = 0`. After release: `in_ready = 1`, `sh_in = 0`.
- Single command: push {8'b11010110, n=3, lr=1} with `out_ready = 1`. Required: one cycle later `out_valid = 1` and `out_data = 8'b10110110`; `count` returns to 0.
- Right rotate: push {8'b11010110, n=2, lr=0}. Required: `out_data = 8'b10110101`. Then push n=0, required: `out_data = 8'b11010110`.
- Fill and stall: `out_ready = 0`, push 6 commands back-to-back.
  - Required: the first command lands in the output register; 4 are queued (`count = 4`, `in_ready = 0`); the 6th is held pending.
  - Release `out_ready`. Required: all 6 results appear in order, each held until taken.
- Streaming with wrap-around: 20 commands, `in_n` = i mod 8, `lr` alternating, random `in_valid`/`out_ready` bubbles. Required: results match a rotate reference model in order, pointers wrap cleanly, and `count` never exceeds 4.
- Simultaneous push and pop at `count = 2`: Required: `count` stays 2, and `out_data` is the result of the older head command.
